// File: rtl/efuse_usr_prog_ctrl.sv
// User eFUSE word sequencer: read, conflict check, per-bit timed program strobe, verify.
// Optional lock-fuse check (SHADOW[31]) enabled by defining EFUSE_USR_CTRL_LOCK_EN.
module efuse_usr_prog_ctrl #(
   parameter int unsigned READ_CYCLES = 2,
   parameter int unsigned PROG_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] DATA_IN,
   input  logic [31:0] EFUSEUSR,
   output logic        FUSE_PROG,
   output logic [4:0]  FUSE_ADDR,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [1:0]  ERR_CODE,
   output logic [31:0] SHADOW
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_PROG,
      S_GAP,
      S_VERIFY,
      S_DONE
   } state_t;

   localparam logic [15:0] READ_LD = 16'(READ_CYCLES - 1);
   localparam logic [15:0] PROG_LD = 16'(PROG_CYCLES - 1);
   localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES - 1);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CONFLICT = 2'b01;
   localparam logic [1:0] ERR_VERIFY   = 2'b10;
`ifdef EFUSE_USR_CTRL_LOCK_EN
   localparam logic [1:0] ERR_LOCKED   = 2'b11;
`endif

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [31:0] target_q;
   logic [31:0] pend_q;
   logic [31:0] shadow_q;
   logic        fuse_prog_q;
   logic [4:0]  fuse_addr_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [1:0]  err_code_q;

   logic [31:0] pend_chk;
   logic [31:0] conflict;
   logic [31:0] pend_nxt;
   logic [4:0]  addr_chk;
   logic [4:0]  addr_nxt;

   // Returns the index of the lowest set bit (0 when v is zero).
   function automatic logic [4:0] lsb_idx(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

   assign pend_chk = target_q & ~shadow_q;
   assign conflict = shadow_q & ~target_q;
   assign pend_nxt = pend_q & ~(32'd1 << fuse_addr_q);
   assign addr_chk = lsb_idx(pend_chk);
   assign addr_nxt = lsb_idx(pend_nxt);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         target_q    <= '0;
         pend_q      <= '0;
         shadow_q    <= '0;
         fuse_prog_q <= 1'b0;
         fuse_addr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  target_q   <= DATA_IN;
                  err_q      <= 1'b0;
                  err_code_q <= ERR_NONE;
                  busy_q     <= 1'b1;
                  cnt_q      <= READ_LD;
                  state_q    <= S_READ;
               end
            end
            S_READ: begin
               if (cnt_q == '0) begin
                  shadow_q <= EFUSEUSR;
                  state_q  <= S_CHECK;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            S_CHECK: begin
`ifdef EFUSE_USR_CTRL_LOCK_EN
               if (shadow_q[31]) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_LOCKED;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
               end else
`endif
               if (|conflict) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_CONFLICT;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= S_DONE;
               end else if (pend_chk == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  pend_q      <= pend_chk;
                  fuse_addr_q <= addr_chk;
                  fuse_prog_q <= 1'b1;
                  cnt_q       <= PROG_LD;
                  state_q     <= S_PROG;
               end
            end
            S_PROG: begin
               if (cnt_q == '0) begin
                  fuse_prog_q <= 1'b0;
                  cnt_q       <= GAP_LD;
                  state_q     <= S_GAP;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            S_GAP: begin
               if (cnt_q == '0) begin
                  pend_q <= pend_nxt;
                  if (|pend_nxt) begin
                     fuse_addr_q <= addr_nxt;
                     fuse_prog_q <= 1'b1;
                     cnt_q       <= PROG_LD;
                     state_q     <= S_PROG;
                  end else begin
                     fuse_addr_q <= '0;
                     cnt_q       <= READ_LD;
                     state_q     <= S_VERIFY;
                  end
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            S_VERIFY: begin
               if (cnt_q == '0) begin
                  shadow_q <= EFUSEUSR;
                  if (EFUSEUSR != target_q) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_VERIFY;
                  end
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign FUSE_PROG = fuse_prog_q;
   assign FUSE_ADDR = fuse_addr_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR       = err_q;
   assign ERR_CODE  = err_code_q;
   assign SHADOW    = shadow_q;

endmodule

// File: tb/tb_efuse_usr_prog_ctrl.sv
// Bench for efuse_usr_prog_ctrl: fuse-array model plus a transaction-level reference model.
module tb_efuse_usr_prog_ctrl;

   localparam int R = 2;
   localparam int P = 16;
   localparam int G = 4;
   localparam int BUDGET = 2 * R + 2 + 33 * (P + G) + 10;
`ifdef EFUSE_USR_CTRL_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [31:0] DATA_IN;
   logic [31:0] EFUSEUSR;
   logic        FUSE_PROG;
   logic [4:0]  FUSE_ADDR;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [1:0]  ERR_CODE;
   logic [31:0] SHADOW;

   logic [31:0] fuse;
   logic [31:0] ign_mask;
   logic        load_req;
   logic [31:0] load_val;

   int checks = 0;
   int failures = 0;

   efuse_usr_prog_ctrl #(.READ_CYCLES(R), .PROG_CYCLES(P), .GAP_CYCLES(G)) dut (
      .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN), .EFUSEUSR(EFUSEUSR),
      .FUSE_PROG(FUSE_PROG), .FUSE_ADDR(FUSE_ADDR), .BUSY(BUSY), .DONE(DONE),
      .ERR(ERR), .ERR_CODE(ERR_CODE), .SHADOW(SHADOW)
   );

   always #5 CLK = ~CLK;

   assign EFUSEUSR = fuse;

   // Array model: a strobed bit blows unless it is marked as defective.
   always @(negedge CLK) begin
      if (load_req) fuse <= load_val;
      else if (FUSE_PROG === 1'b1 && !ign_mask[FUSE_ADDR]) fuse[FUSE_ADDR] <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fuse(input logic [31:0] v);
      @(negedge CLK);
      load_val = v;
      load_req = 1'b1;
      @(negedge CLK);
      #1 load_req = 1'b0;
   endtask

   task automatic run_txn(input string tag, input logic [31:0] t, input bit pulse_start);
      logic [31:0] f0, pend, fin, exp_shadow;
      logic [1:0]  exp_code;
      int          exp_done, exp_n;
      int          exp_addr[$];
      int          addr_q[$];
      int          start_q[$];
      int          cyc, done_cyc, run, len_bad, busy_bad, addr_bad;
      logic        prev, err_c1, err_d;
      logic [1:0]  code_d;
      logic [31:0] shadow_d;
      logic [4:0]  addr_d;

      f0 = fuse;
      exp_addr.delete();
      if (LOCK_EN && f0[31]) begin
         exp_code = 2'b11; exp_shadow = f0; exp_done = R + 2;
      end else if ((f0 & ~t) != 0) begin
         exp_code = 2'b01; exp_shadow = f0; exp_done = R + 2;
      end else begin
         pend = t & ~f0;
         for (int i = 0; i < 32; i++) if (pend[i]) exp_addr.push_back(i);
         fin = f0 | (pend & ~ign_mask);
         exp_shadow = (exp_addr.size() == 0) ? f0 : fin;
         exp_code = (exp_shadow == t) ? 2'b00 : 2'b10;
         exp_done = (exp_addr.size() == 0) ? R + 2 : 2 * R + 2 + exp_addr.size() * (P + G);
      end
      exp_n = exp_addr.size();

      @(negedge CLK);
      START = 1'b1;
      DATA_IN = t;
      @(posedge CLK);
      cyc = 0; done_cyc = -1; run = 0; prev = 1'b0;
      len_bad = 0; busy_bad = 0; addr_bad = 0;
      err_c1 = 1'bx; err_d = 1'bx; code_d = 2'bxx; shadow_d = 'x; addr_d = 'x;
      while (done_cyc < 0 && cyc < BUDGET) begin
         @(negedge CLK);
         cyc++;
         START = (pulse_start && FUSE_PROG === 1'b1);
         DATA_IN = $urandom;
         if (cyc == 1) err_c1 = ERR;
         if (FUSE_PROG === 1'b1) begin
            if (!prev) begin
               addr_q.push_back(int'(FUSE_ADDR));
               start_q.push_back(cyc);
               run = 1;
            end else begin
               run++;
               if (int'(FUSE_ADDR) != addr_q[$]) addr_bad++;
            end
         end else if (prev && run != P) len_bad++;
         prev = (FUSE_PROG === 1'b1);
         if (BUSY !== ~DONE) busy_bad++;
         if (DONE === 1'b1) begin
            done_cyc = cyc; err_d = ERR; code_d = ERR_CODE; shadow_d = SHADOW; addr_d = FUSE_ADDR;
         end
      end
      START = 1'b0;

      check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
      check({tag, ".err_clr"}, 32'(err_c1), 32'd0);
      check({tag, ".err"}, 32'(err_d), 32'(exp_code != 2'b00));
      check({tag, ".err_code"}, 32'(code_d), 32'(exp_code));
      check({tag, ".shadow"}, shadow_d, exp_shadow);
      check({tag, ".addr_at_done"}, 32'(addr_d), 32'd0);
      check({tag, ".strobes"}, 32'(addr_q.size()), 32'(exp_n));
      for (int k = 0; k < exp_n && k < addr_q.size(); k++) begin
         check($sformatf("%s.addr%0d", tag, k), 32'(addr_q[k]), 32'(exp_addr[k]));
         check($sformatf("%s.start%0d", tag, k), 32'(start_q[k]), 32'(R + 2 + k * (P + G)));
      end
      check({tag, ".strobe_len_bad"}, 32'(len_bad), 32'd0);
      check({tag, ".addr_hold_bad"}, 32'(addr_bad), 32'd0);
      check({tag, ".busy_bad"}, 32'(busy_bad), 32'd0);
      @(negedge CLK);
      check({tag, ".done_pulse"}, {30'd0, DONE, BUSY}, 32'd0);
   endtask

   initial begin
      logic [31:0] f, t;
      int mode;
      RST = 1'b1; START = 1'b0; DATA_IN = '0; ign_mask = '0; load_req = 1'b0; load_val = '0;
      set_fuse(32'h0);
      check("reset.outputs", {23'd0, FUSE_PROG, FUSE_ADDR, BUSY, DONE, ERR}, 32'd0);
      check("reset.code_shadow", {SHADOW[29:0], ERR_CODE}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      run_txn("blank", 32'h0000_0005, 1'b0);
      set_fuse(32'hA5A5_A5A5);
      run_txn("noop", 32'hA5A5_A5A5, 1'b0);
      set_fuse(32'h0000_0010);
      run_txn("conflict", 32'h0000_0001, 1'b0);
      repeat (5) @(negedge CLK);
      check("conflict.err_hold", {29'd0, ERR, ERR_CODE}, 32'h5);

      ign_mask = 32'h0000_0008;
      set_fuse(32'h0);
      run_txn("vfail", 32'h0000_0008, 1'b1);
      ign_mask = '0;

      set_fuse(32'h8000_0000);
      run_txn("lock", 32'h8000_0001, 1'b0);

      // Reset during the first strobe, then resume with the same request.
      set_fuse(32'h0);
      @(negedge CLK);
      START = 1'b1; DATA_IN = 32'h0000_0005;
      @(negedge CLK);
      START = 1'b0;
      for (int i = 0; i < 50 && FUSE_PROG !== 1'b1; i++) @(negedge CLK);
      check("rst.prog_seen", 32'(FUSE_PROG), 32'd1);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      #1 check("rst.prog_drop", 32'(FUSE_PROG), 32'd0);
      check("rst.outputs", {23'd0, FUSE_PROG, FUSE_ADDR, BUSY, DONE, ERR}, 32'd0);
      check("rst.shadow", SHADOW, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      check("rst.partial_fuse", fuse, 32'h0000_0001);
      run_txn("rst_resume", 32'h0000_0005, 1'b0);

      for (int it = 0; it < 8; it++) begin
         f = $urandom & $urandom & $urandom & 32'h7FFF_FFFF;
         mode = int'($urandom_range(0, 3));
         ign_mask = '0;
         case (mode)
            0: t = f | ($urandom & $urandom & $urandom & $urandom);
            1: t = $urandom & $urandom & $urandom;
            2: t = f;
            default: begin
               t = f | ($urandom & $urandom & $urandom & $urandom) | (32'd1 << $urandom_range(0, 31));
               ign_mask = $urandom & $urandom;
            end
         endcase
         set_fuse(f);
         run_txn($sformatf("rnd%0d", it), t, bit'($urandom_range(0, 1)));
      end
      ign_mask = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
